memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Memory-access stage directly upstream of the writeback stage.
- Takes execute results (ALU result/address, store data, load/store control, destination register) and runs loads/stores on a valid/ready data-memory bus.
- Load data is aligned and sign/zero-extended; stores get byte strobes.
- Produces registered, single-cycle-valid outputs for writeback: io_opWrite, io_opSel, io_opReg, io_ALU_Result, io_memory_data.

Parameters:
RSP_TIMEOUT, 255, cycles to wait for io_mem_rsp_valid after a load request is accepted before aborting with io_bus_error; 0 disables the timeout.

Ports:
clock  input  1  sole clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
io_in_valid  input  1  upstream instruction valid
io_in_ready  output  1  stage can accept; high only in IDLE
io_load  input  1  instruction is a load
io_store  input  1  instruction is a store (io_load and io_store never both 1)
io_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
io_address  input  32  ALU result; the effective address for loads/stores
io_store_data  input  32  rs2 value for stores
io_in_opWrite  input  1  instruction writes a register
io_in_opReg  input  5  destination register
io_mem_req_valid  output  1  bus request valid
io_mem_req_ready  input  1  bus accepts request
io_mem_we  output  1  1 = store, 0 = load
io_mem_addr  output  32  {io_address[31:2], 2'b00}
io_mem_wdata  output  32  lane-replicated store data
io_mem_wstrb  output  4  byte enables; 0000 for loads
io_mem_rsp_valid  input  1  load data valid
io_mem_rdata  input  32  load word
io_wb_valid  output  1  one-cycle completion pulse to writeback
io_opWrite  output  1  register write enable to writeback
io_opSel  output  1  1 = memory data, 0 = ALU result
io_opReg  output  5  destination register
io_ALU_Result  output  32  registered io_address
io_memory_data  output  32  extended load data
io_misaligned  output  1  pulse with io_wb_valid on misaligned access
io_bus_error  output  1  pulse with io_wb_valid on response timeout

Behaviour:
- Reset (reset=0, async): state IDLE, timeout counter 0.
  - All outputs 0, except io_in_ready = 1.
  - Reset mid-transaction drops the transaction: no io_wb_valid, io_mem_req_valid falls immediately.
- States:
  - IDLE: io_in_ready=1. On io_in_valid:
    - non-memory op -> register outputs and pulse io_wb_valid next cycle; stay IDLE (1-cycle latency, back-to-back throughput).
    - misaligned access -> same as non-memory op but with io_opWrite=0 and io_misaligned=1; no bus activity.
      - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
    - aligned load/store -> latch request, go to REQ.
  - REQ: io_mem_req_valid=1; addr/we/wdata/wstrb held stable until the cycle io_mem_req_ready=1.
    - Store accepted -> completion next cycle (opWrite=0, opSel=0), return to IDLE.
    - Load accepted -> go to WAIT, clear the counter.
  - WAIT: io_mem_req_valid=0.
    - io_mem_rsp_valid=1 -> capture extended data, completion next cycle (opWrite=latched, opSel=1), return to IDLE.
    - Counter reaches RSP_TIMEOUT (nonzero) first -> completion with opWrite=0, io_bus_error=1, io_memory_data=0, return to IDLE.
    - A response arriving in the same cycle as the timeout wins.
    - A response while in IDLE or REQ is ignored.
- Completion outputs are registered. io_wb_valid, io_opWrite, io_misaligned and io_bus_error are high for exactly one cycle. io_opSel/io_opReg/io_ALU_Result/io_memory_data hold until the next completion.
- Latency: ALU op 1 cycle; store 1 cycle + req wait + 1; load 1 cycle + req wait + rsp wait + 1. io_in_ready is low from the cycle after a memory op is accepted until the stage is back in IDLE.
- Store lanes:
  - B: byte replicated into all 4 lanes, wstrb = 0001 << addr[1:0].
  - H: halfword in both halves, wstrb = 0011 << addr[1:0].
  - W: wstrb = 1111.
- Load extract: byte/half selected by addr[1:0]. B/H sign-extend; BU/HU zero-extend. Undefined funct3 codes are treated as W.
- io_opReg is forwarded unchanged. io_opWrite is never forced for r0; the register file ignores r0.

Test Plan:
- ALU op, addr=0x1234, opWrite=1, opReg=5 -> next cycle wb_valid=1, opSel=0, ALU_Result=0x1234, opReg=5, opWrite=1; back-to-back issue keeps in_ready=1.
- LB addr=0x103, rdata=0x80FF_1122, req_ready after 2 cycles, rsp after 3 -> mem_addr=0x100, wstrb=0000, memory_data=0xFFFF_FF80, opSel=1, in_ready low throughout.
- LHU addr=0x102, rdata=0x8001_0000 -> memory_data=0x0000_8001.
- SB addr=0x21, store_data=0xAB, req_ready=1 -> wdata=0xABAB_ABAB, wstrb=0010, we=1; completion with opWrite=0.
- LW addr=0x102 -> no req_valid, wb_valid with misaligned=1, opWrite=0; LW with RSP_TIMEOUT=4 and no rsp -> bus_error pulse 4 cycles after acceptance.
- Reset asserted in WAIT -> req_valid/wb_valid 0 immediately, in_ready=1 after release; a late rsp_valid then produces no completion.

Source files
------------

// File: rtl/memory_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// memory_stage_if: valid/ready data-memory bus for memory_stage. Rev 1.0
// ----------------------------------------------------------------------
interface memory_stage_if;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready;
  logic        io_mem_we;
  logic [31:0] io_mem_addr;
  logic [31:0] io_mem_wdata;
  logic [3:0]  io_mem_wstrb;
  logic        io_mem_rsp_valid;
  logic [31:0] io_mem_rdata;

  modport master (
    output io_mem_req_valid, io_mem_we, io_mem_addr, io_mem_wdata, io_mem_wstrb,
    input  io_mem_req_ready, io_mem_rsp_valid, io_mem_rdata
  );

  modport slave (
    input  io_mem_req_valid, io_mem_we, io_mem_addr, io_mem_wdata, io_mem_wstrb,
    output io_mem_req_ready, io_mem_rsp_valid, io_mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ----------------------------------------------------------------------
// memory_stage: load/store stage between execute and writeback. Rev 1.0
// ----------------------------------------------------------------------
module memory_stage #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_in_valid,
  output logic          io_in_ready,
  input  logic          io_load,
  input  logic          io_store,
  input  logic [2:0]    io_funct3,
  input  logic [31:0]   io_address,
  input  logic [31:0]   io_store_data,
  input  logic          io_in_opWrite,
  input  logic [4:0]    io_in_opReg,
  memory_stage_if.master mem,
  output logic          io_wb_valid,
  output logic          io_opWrite,
  output logic          io_opSel,
  output logic [4:0]    io_opReg,
  output logic [31:0]   io_ALU_Result,
  output logic [31:0]   io_memory_data,
  output logic          io_misaligned,
  output logic          io_bus_error
);
  localparam int            CW       = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);
  localparam bit            TMO_EN   = (RSP_TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic        lat_opwrite_q;
  logic [4:0]  lat_opreg_q;

  logic        wb_valid_q, opwrite_q, opsel_q, mis_q, berr_q;
  logic [4:0]  opreg_q;
  logic [31:0] alu_q, mdata_q;

  logic        done, lat_en;
  logic        opwrite_d, opsel_d, mis_d, berr_d;
  logic [4:0]  opreg_d;
  logic [31:0] alu_d, mdata_d;

  logic        in_misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // funct3[1:0] gives the access size; unknown sizes behave as a word
  always_comb begin
    in_misaligned = 1'b0;
    st_wdata      = io_store_data;
    st_wstrb      = 4'b1111;
    case (io_funct3[1:0])
      2'b00: begin
        st_wdata = {4{io_store_data[7:0]}};
        st_wstrb = 4'b0001 << io_address[1:0];
      end
      2'b01: begin
        st_wdata      = {2{io_store_data[15:0]}};
        st_wstrb      = 4'b0011 << io_address[1:0];
        in_misaligned = io_address[0];
      end
      default: in_misaligned = |io_address[1:0];
    endcase
  end

  always_comb begin
    ld_byte = mem.io_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem.io_mem_rdata[31:16] : mem.io_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem.io_mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_en    = 1'b0;
    done      = 1'b0;
    opwrite_d = 1'b0;
    opsel_d   = 1'b0;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    mdata_d   = '0;
    alu_d     = addr_q;
    opreg_d   = lat_opreg_q;
    case (state_q)
      S_IDLE: begin
        if (io_in_valid) begin
          alu_d   = io_address;
          opreg_d = io_in_opReg;
          if (!(io_load || io_store)) begin
            done      = 1'b1;
            opwrite_d = io_in_opWrite;
          end else if (in_misaligned) begin
            done  = 1'b1;
            mis_d = 1'b1;
          end else begin
            lat_en  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem.io_mem_req_ready) begin
          if (we_q) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // a response in the timeout cycle still completes normally
        if (mem.io_mem_rsp_valid) begin
          done      = 1'b1;
          opwrite_d = lat_opwrite_q;
          opsel_d   = 1'b1;
          mdata_d   = ld_data;
          state_d   = S_IDLE;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          done    = 1'b1;
          berr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (TMO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      lat_opwrite_q <= 1'b0;
      lat_opreg_q   <= '0;
      wb_valid_q    <= 1'b0;
      opwrite_q     <= 1'b0;
      opsel_q       <= 1'b0;
      mis_q         <= 1'b0;
      berr_q        <= 1'b0;
      opreg_q       <= '0;
      alu_q         <= '0;
      mdata_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= done;
      opwrite_q  <= opwrite_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
      if (done) begin
        opsel_q <= opsel_d;
        opreg_q <= opreg_d;
        alu_q   <= alu_d;
        mdata_q <= mdata_d;
      end
      if (lat_en) begin
        addr_q        <= io_address;
        wdata_q       <= st_wdata;
        wstrb_q       <= io_store ? st_wstrb : 4'b0000;
        we_q          <= io_store;
        funct3_q      <= io_funct3;
        lat_opwrite_q <= io_in_opWrite;
        lat_opreg_q   <= io_in_opReg;
      end
    end
  end

  assign io_in_ready          = (state_q == S_IDLE);
  assign mem.io_mem_req_valid = (state_q == S_REQ);
  assign mem.io_mem_we        = we_q;
  assign mem.io_mem_addr      = {addr_q[31:2], 2'b00};
  assign mem.io_mem_wdata     = wdata_q;
  assign mem.io_mem_wstrb     = wstrb_q;

  assign io_wb_valid    = wb_valid_q;
  assign io_opWrite     = opwrite_q;
  assign io_opSel       = opsel_q;
  assign io_opReg       = opreg_q;
  assign io_ALU_Result  = alu_q;
  assign io_memory_data = mdata_q;
  assign io_misaligned  = mis_q;
  assign io_bus_error   = berr_q;
endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_memory_stage: randomized self-checking bench for memory_stage. Rev 1.0
// ----------------------------------------------------------------------
module tb_memory_stage;
  localparam int TMO = 4;

  logic        clock, reset;
  logic        io_in_valid, io_in_ready, io_load, io_store;
  logic [2:0]  io_funct3;
  logic [31:0] io_address, io_store_data;
  logic        io_in_opWrite;
  logic [4:0]  io_in_opReg;
  logic        io_wb_valid, io_opWrite, io_opSel, io_misaligned, io_bus_error;
  logic [4:0]  io_opReg;
  logic [31:0] io_ALU_Result, io_memory_data;

  int checks = 0;
  int errors = 0;

  memory_stage_if mem_bus ();

  memory_stage #(.RSP_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_load(io_load), .io_store(io_store), .io_funct3(io_funct3),
    .io_address(io_address), .io_store_data(io_store_data),
    .io_in_opWrite(io_in_opWrite), .io_in_opReg(io_in_opReg),
    .mem(mem_bus),
    .io_wb_valid(io_wb_valid), .io_opWrite(io_opWrite), .io_opSel(io_opSel),
    .io_opReg(io_opReg), .io_ALU_Result(io_ALU_Result), .io_memory_data(io_memory_data),
    .io_misaligned(io_misaligned), .io_bus_error(io_bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          ready_at_issue, req_seen, stable, ready_low, wait_req_low, done, ready_at_done, held;
    bit          nxt_pulse;
    int          lat;
    logic        we, opw, opsel, mis, berr;
    logic [31:0] addr, wdata, alu, mdata;
    logic [3:0]  wstrb;
    logic [4:0]  oreg;
  } obs_t;

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + m_size(f3));
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n = m_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int n = m_size(f3);
    if (n == 4) return rd;
    v = (longint'(rd) >> (8 * (a % 4))) & ((64'sd1 << (8 * n)) - 1);
    if (!f3[2] && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
    return 32'(v);
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input bit opw, input logic [4:0] rg,
                         input int req_dly, input int rsp_dly, input logic [31:0] rd, output obs_t o);
    o = '{default: 0};
    o.ready_at_issue = io_in_ready;
    io_in_valid = 1'b1; io_load = ld; io_store = st; io_funct3 = f3;
    io_address = a; io_store_data = sd; io_in_opWrite = opw; io_in_opReg = rg;
    step();
    io_in_valid = 1'b0; io_load = 1'b0; io_store = 1'b0;
    io_address = $urandom; io_store_data = $urandom;
    o.req_seen = mem_bus.io_mem_req_valid;
    o.stable = 1; o.ready_low = 1; o.wait_req_low = 1;
    if (o.req_seen) begin
      o.addr = mem_bus.io_mem_addr; o.we = mem_bus.io_mem_we;
      o.wdata = mem_bus.io_mem_wdata; o.wstrb = mem_bus.io_mem_wstrb;
      if (io_in_ready) o.ready_low = 0;
      for (int i = 0; i < req_dly; i++) begin
        step();
        if (!mem_bus.io_mem_req_valid || mem_bus.io_mem_addr !== o.addr || mem_bus.io_mem_we !== o.we ||
            mem_bus.io_mem_wdata !== o.wdata || mem_bus.io_mem_wstrb !== o.wstrb) o.stable = 0;
        if (io_in_ready || io_wb_valid) o.ready_low = 0;
      end
      mem_bus.io_mem_req_ready = 1'b1;
      step();
      mem_bus.io_mem_req_ready = 1'b0;
      for (int k = 0; k < 20 && !io_wb_valid; k++) begin
        if (mem_bus.io_mem_req_valid) o.wait_req_low = 0;
        if (io_in_ready) o.ready_low = 0;
        if (k == rsp_dly) begin
          mem_bus.io_mem_rsp_valid = 1'b1;
          mem_bus.io_mem_rdata = rd;
        end
        step();
        mem_bus.io_mem_rsp_valid = 1'b0;
        mem_bus.io_mem_rdata = $urandom;
        o.lat = k + 1;
      end
    end
    o.done = io_wb_valid; o.ready_at_done = io_in_ready;
    o.opw = io_opWrite; o.opsel = io_opSel; o.oreg = io_opReg;
    o.alu = io_ALU_Result; o.mdata = io_memory_data; o.mis = io_misaligned; o.berr = io_bus_error;
    step();
    o.nxt_pulse = io_wb_valid | io_opWrite | io_misaligned | io_bus_error;
    o.held = (io_opSel === o.opsel) && (io_opReg === o.oreg) &&
             (io_ALU_Result === o.alu) && (io_memory_data === o.mdata);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    checks++; if (io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", io_in_ready); end
    checks++; if ({io_wb_valid, io_opWrite, io_opSel, io_misaligned, io_bus_error, mem_bus.io_mem_req_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
        {io_wb_valid, io_opWrite, io_opSel, io_misaligned, io_bus_error, mem_bus.io_mem_req_valid}); end
    checks++; if ({io_opReg, io_ALU_Result, io_memory_data} !== 69'b0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h expected 0", io_opReg, io_ALU_Result, io_memory_data); end
    checks++; if ({mem_bus.io_mem_we, mem_bus.io_mem_wstrb, mem_bus.io_mem_addr} !== 37'b0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", {mem_bus.io_mem_we, mem_bus.io_mem_wstrb, mem_bus.io_mem_addr}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_alu();
    obs_t o;
    run_txn(0, 0, 3'b010, 32'h1234, 32'h0, 1, 5'd5, 0, 0, 32'h0, o);
    checks++; if (o.done !== 1'b1) begin errors++; $display("FAIL alu_wb_valid: got %b expected 1", o.done); end
    checks++; if (o.req_seen !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b expected 0", o.req_seen); end
    checks++; if ({o.opw, o.opsel} !== 2'b10) begin errors++; $display("FAIL alu_opw_opsel: got %b expected 10", {o.opw, o.opsel}); end
    checks++; if (o.alu !== 32'h1234) begin errors++; $display("FAIL alu_result: got %h expected 00001234", o.alu); end
    checks++; if (o.oreg !== 5'd5) begin errors++; $display("FAIL alu_opreg: got %0d expected 5", o.oreg); end
    checks++; if (o.nxt_pulse !== 1'b0) begin errors++; $display("FAIL alu_pulse_width: got %b expected 0", o.nxt_pulse); end
    checks++; if (o.held !== 1'b1) begin errors++; $display("FAIL alu_hold: got %b expected 1", o.held); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [4:0]  r [4];
    logic        w [4];
    for (int i = 0; i < 4; i++) begin a[i] = $urandom; r[i] = 5'($urandom); w[i] = 1'($urandom); end
    io_load = 0; io_store = 0; io_in_valid = 1;
    io_address = a[0]; io_in_opReg = r[0]; io_in_opWrite = w[0];
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin io_address = a[i+1]; io_in_opReg = r[i+1]; io_in_opWrite = w[i+1]; end
      else io_in_valid = 0;
      checks++; if ({io_wb_valid, io_in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_valid_ready[%0d]: got %b expected 11", i, {io_wb_valid, io_in_ready}); end
      checks++; if ({io_ALU_Result, io_opReg, io_opWrite} !== {a[i], r[i], w[i]}) begin
        errors++; $display("FAIL b2b_data[%0d]: got %h/%0d/%b expected %h/%0d/%b", i, io_ALU_Result, io_opReg, io_opWrite, a[i], r[i], w[i]); end
    end
    step();
    checks++; if (io_wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", io_wb_valid); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_txn(1, 0, 3'b000, 32'h103, 32'h0, 1, 5'd7, 2, 3, 32'h80FF_1122, o);
    checks++; if (o.req_seen !== 1'b1) begin errors++; $display("FAIL lb_req: got %b expected 1", o.req_seen); end
    checks++; if ({o.addr, o.wstrb, o.we} !== {32'h100, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL lb_bus: got %h/%b/%b expected 00000100/0000/0", o.addr, o.wstrb, o.we); end
    checks++; if ({o.stable, o.ready_low, o.wait_req_low} !== 3'b111) begin errors++; $display("FAIL lb_handshake: got %b expected 111", {o.stable, o.ready_low, o.wait_req_low}); end
    checks++; if (o.mdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", o.mdata); end
    checks++; if ({o.done, o.opsel, o.opw, o.berr} !== 4'b1110) begin errors++; $display("FAIL lb_wb: got %b expected 1110", {o.done, o.opsel, o.opw, o.berr}); end
    checks++; if (o.lat !== 4) begin errors++; $display("FAIL lb_rsp_latency: got %0d expected 4", o.lat); end
  endtask

  task automatic test_load_half();
    obs_t o;
    run_txn(1, 0, 3'b101, 32'h102, 32'h0, 1, 5'd9, 0, 0, 32'h8001_0000, o);
    checks++; if (o.mdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: got %h expected 00008001", o.mdata); end
    checks++; if ({o.done, o.opsel, o.oreg} !== {1'b1, 1'b1, 5'd9}) begin errors++; $display("FAIL lhu_wb: got %b/%b/%0d expected 1/1/9", o.done, o.opsel, o.oreg); end
  endtask

  task automatic test_store_byte();
    obs_t o;
    run_txn(0, 1, 3'b000, 32'h21, 32'h0000_00AB, 1, 5'd3, 0, 0, 32'h0, o);
    checks++; if (o.wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h expected abababab", o.wdata); end
    checks++; if ({o.wstrb, o.we, o.addr} !== {4'b0010, 1'b1, 32'h20}) begin errors++; $display("FAIL sb_bus: got %b/%b/%h expected 0010/1/00000020", o.wstrb, o.we, o.addr); end
    checks++; if ({o.done, o.opw, o.opsel, o.lat} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin errors++; $display("FAIL sb_wb: got %b%b%b lat %0d expected 100 lat 0", o.done, o.opw, o.opsel, o.lat); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_txn(1, 0, 3'b010, 32'h102, 32'h0, 1, 5'd4, 0, 0, 32'h0, o);
    checks++; if (o.req_seen !== 1'b0) begin errors++; $display("FAIL lw_mis_no_req: got %b expected 0", o.req_seen); end
    checks++; if ({o.done, o.mis, o.opw, o.alu} !== {3'b110, 32'h102}) begin errors++; $display("FAIL lw_mis_wb: got %b%b%b/%h expected 110/00000102", o.done, o.mis, o.opw, o.alu); end
    checks++; if (o.nxt_pulse !== 1'b0) begin errors++; $display("FAIL lw_mis_pulse: got %b expected 0", o.nxt_pulse); end
    run_txn(0, 1, 3'b001, 32'h77, 32'h1234, 1, 5'd4, 0, 0, 32'h0, o);
    checks++; if ({o.req_seen, o.done, o.mis, o.opw} !== 4'b0110) begin errors++; $display("FAIL sh_mis: got %b expected 0110", {o.req_seen, o.done, o.mis, o.opw}); end
  endtask

  task automatic test_timeout();
    obs_t o;
    for (int t = 0; t < 2; t++) begin
      run_txn(1, 0, 3'b010, 32'h200, 32'h0, 1, 5'd11, 1, 99, 32'h0, o);
      checks++; if ({o.done, o.berr, o.opw, o.mis} !== 4'b1100) begin errors++; $display("FAIL tmo_wb[%0d]: got %b expected 1100", t, {o.done, o.berr, o.opw, o.mis}); end
      checks++; if (o.lat !== TMO) begin errors++; $display("FAIL tmo_latency[%0d]: got %0d expected %0d", t, o.lat, TMO); end
      checks++; if (o.mdata !== 32'h0) begin errors++; $display("FAIL tmo_data[%0d]: got %h expected 0", t, o.mdata); end
      checks++; if ({o.nxt_pulse, o.ready_at_done} !== 2'b01) begin errors++; $display("FAIL tmo_after[%0d]: got %b expected 01", t, {o.nxt_pulse, o.ready_at_done}); end
    end
  endtask

  task automatic test_reset_midflight();
    io_in_valid = 1; io_load = 1; io_funct3 = 3'b010; io_address = 32'h40; io_in_opWrite = 1; io_in_opReg = 5'd2;
    step();
    io_in_valid = 0; io_load = 0;
    checks++; if (mem_bus.io_mem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b expected 1", mem_bus.io_mem_req_valid); end
    reset = 0; #1;
    checks++; if ({mem_bus.io_mem_req_valid, io_in_ready} !== 2'b01) begin errors++; $display("FAIL rst_in_req: got %b expected 01", {mem_bus.io_mem_req_valid, io_in_ready}); end
    step(); reset = 1; step();
    io_in_valid = 1; io_load = 1;
    step();
    io_in_valid = 0; io_load = 0;
    mem_bus.io_mem_req_ready = 1; step(); mem_bus.io_mem_req_ready = 0;
    step();
    reset = 0; #1;
    checks++; if ({mem_bus.io_mem_req_valid, io_wb_valid, io_in_ready} !== 3'b001) begin errors++; $display("FAIL rst_in_wait: got %b expected 001", {mem_bus.io_mem_req_valid, io_wb_valid, io_in_ready}); end
    step(); reset = 1;
    mem_bus.io_mem_rsp_valid = 1; mem_bus.io_mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_bus.io_mem_rsp_valid = 0;
    step();
    checks++; if ({io_wb_valid, io_in_ready, io_opSel} !== 3'b010) begin errors++; $display("FAIL rst_late_rsp: got %b expected 010", {io_wb_valid, io_in_ready, io_opSel}); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 40; n++) begin
      int kind = int'($urandom_range(0, 2));
      bit ld = (kind == 1), st = (kind == 2);
      logic [2:0]  f3 = st ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      logic [31:0] a = $urandom, sd = $urandom, rd = $urandom;
      bit          opw = 1'($urandom);
      logic [4:0]  rg = 5'($urandom);
      int rq = int'($urandom_range(0, 3)), rs = int'($urandom_range(0, TMO - 1));
      bit m = (ld || st) && m_mis(f3, a);
      bit busop = (ld || st) && !m;
      bit e_opw = (!ld && !st) ? opw : (ld && !m) ? opw : 1'b0;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      m = (ld || st) && m_mis(f3, a);
      busop = (ld || st) && !m;
      e_opw = (!ld && !st) ? opw : (ld && !m) ? opw : 1'b0;
      run_txn(ld, st, f3, a, sd, opw, rg, rq, rs, rd, o);
      checks++; if ({o.ready_at_issue, o.done, o.ready_at_done, o.req_seen} !== {3'b111, busop}) begin
        errors++; $display("FAIL rnd_flow[%0d]: got %b expected 111%b", n, {o.ready_at_issue, o.done, o.ready_at_done, o.req_seen}, busop); end
      checks++; if ({o.opw, o.opsel, o.mis, o.berr} !== {e_opw, ld && !m, m, 1'b0}) begin
        errors++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", n, {o.opw, o.opsel, o.mis, o.berr}, {e_opw, ld && !m, m, 1'b0}); end
      checks++; if ({o.alu, o.oreg} !== {a, rg}) begin errors++; $display("FAIL rnd_fwd[%0d]: got %h/%0d expected %h/%0d", n, o.alu, o.oreg, a, rg); end
      checks++; if ({o.nxt_pulse, o.held} !== 2'b01) begin errors++; $display("FAIL rnd_pulse_hold[%0d]: got %b expected 01", n, {o.nxt_pulse, o.held}); end
      if (busop) begin
        checks++; if ({o.addr, o.we, o.wstrb} !== {a[31:2], 2'b00, st, st ? m_strb(f3, a) : 4'b0000}) begin
          errors++; $display("FAIL rnd_bus[%0d]: got %h/%b/%b expected %h/%b/%b", n, o.addr, o.we, o.wstrb, {a[31:2], 2'b00}, st, st ? m_strb(f3, a) : 4'b0000); end
        checks++; if ({o.stable, o.ready_low, o.wait_req_low} !== 3'b111) begin errors++; $display("FAIL rnd_handshake[%0d]: got %b expected 111", n, {o.stable, o.ready_low, o.wait_req_low}); end
        if (st) begin
          checks++; if (o.wdata !== m_wdata(f3, sd)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, o.wdata, m_wdata(f3, sd)); end
        end else begin
          checks++; if (o.mdata !== m_load(f3, a, rd)) begin errors++; $display("FAIL rnd_ldata[%0d] f3=%b a=%h rd=%h: got %h expected %h", n, f3, a, rd, o.mdata, m_load(f3, a, rd)); end
          checks++; if (o.lat !== rs + 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, o.lat, rs + 1); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    io_in_valid = 0; io_load = 0; io_store = 0; io_funct3 = 0;
    io_address = 0; io_store_data = 0; io_in_opWrite = 0; io_in_opReg = 0;
    mem_bus.io_mem_req_ready = 0; mem_bus.io_mem_rsp_valid = 0; mem_bus.io_mem_rdata = 0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_byte();
    test_load_half();
    test_store_byte();
    test_misaligned();
    test_timeout();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
